hub75_bcm_driver: RTL
=====================

Name: hub75_bcm_driver

Overview:
- Parametrised HUB75 LED-panel scanner with binary-coded-modulation (BCM) colour depth.
- Reads pixel pairs (top half and bottom half) from an external synchronous framebuffer, shifts them into the panel, latches them, and drives weighted OE on-times per bit plane.
- Sits between the framebuffer RAM and the panel pins.
- Generalises the fixed 32x32 single-bit scanner to arbitrary width, row-pair count and colour depth, and adds enable and frame-sync.

Parameters:
- PANEL_W, 32, pixels per row, shift length; >=2.
- ROW_PAIRS, 16, scanned row pairs; power of 2. RB = $clog2(ROW_PAIRS).
- BITS, 4, colour bits per channel, i.e. number of bit planes; 1..8.
- OE_BASE, 8, display cycles for plane 0 (LSB); plane b displays OE_BASE<<b cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run scanning; sampled at plane boundaries.
- fb_addr  out  RB+$clog2(PANEL_W)  {row, col} read address.
- fb_rdata  in  6*BITS  {bot_R, bot_G, bot_B, top_R, top_G, top_B}, each BITS wide; valid exactly 1 cycle after fb_addr.
- frame_start  out  1  one-cycle pulse at start of row 0, plane 0.
- PANEL_R0, PANEL_G0, PANEL_B0  out  1 each  top-half colour.
- PANEL_R1, PANEL_G1, PANEL_B1  out  1 each  bottom-half colour.
- PANEL_ADDR  out  RB  row-pair select.
- PANEL_CLK  out  1  shift clock.
- PANEL_STB  out  1  latch, active high.
- PANEL_OE  out  1  output enable, active low.

Behaviour:
- All panel outputs, fb_addr and frame_start are registered.
- Reset values: PANEL_OE=1; all other outputs 0; FSM in IDLE; row=0, plane=0.
- Reset asserted mid-operation: the reset values appear on the next edge, with no partial STB.
- FSM IDLE -> SHIFT: on enable=1. frame_start pulses in the first SHIFT cycle of row 0, plane 0.
- SHIFT: 2*PANEL_W cycles, per pixel x = 0..PANEL_W-1.
  - Cycle 2x: colour pins = bit[plane] of pixel x, PANEL_CLK=0.
  - Cycle 2x+1: PANEL_CLK=1, colour pins held.
  - fb_addr is issued early enough to meet the 1-cycle read latency.
  - PANEL_OE stays as left by the previous DISPLAY (1 on first entry).
- BLANK: 1 cycle. PANEL_OE=1, PANEL_CLK=0, colour pins=0, PANEL_ADDR <= current row.
- LATCH: 1 cycle. PANEL_STB=1, PANEL_OE=1.
- DISPLAY: OE_BASE<<plane cycles with PANEL_OE=0, STB=0, CLK=0.
- After DISPLAY:
  - PANEL_OE=1.
  - plane increments; plane==BITS-1 wraps to 0 and row increments.
  - row==ROW_PAIRS-1 wraps to 0 (frame end).
  - enable=1 -> SHIFT; enable=0 -> IDLE.
  - enable dropping mid-plane never truncates that plane.
- Counter widths: the DISPLAY counter is sized for OE_BASE<<(BITS-1) with no overflow.
- Derived timing:
  - Plane time = 2*PANEL_W + 2 + (OE_BASE<<b).
  - Row time = BITS*(2*PANEL_W+2) + OE_BASE*(2^BITS-1).
  - Frame time = ROW_PAIRS * row time.
- Invariants:
  - PANEL_STB=1 implies PANEL_OE=1.
  - PANEL_ADDR changes only when PANEL_OE=1.
  - PANEL_CLK never high outside SHIFT.

Test Plan:
- Reset then enable=1, defaults -> frame_start first pulses 1 cycle after enable. Next pulse exactly 6144 cycles later; row time 384.
- Row 0 framebuffer = 4'b1010 for top R, 4'b0101 for bottom B, others 0 -> planes 1,3: 32 CLK rising edges with R0=1. Planes 0,2: B1=1. OE-low widths 8,16,32,64 in that order.
- Latch check over one frame -> exactly 4*16 STB pulses. Each preceded by one BLANK cycle. PANEL_ADDR steps 0..15 then wraps to 0. No CLK pulse or OE low while STB=1.
- enable dropped during plane 2 SHIFT of row 5 -> plane 2 completes with 32 OE-low cycles, then IDLE with OE=1. Re-enable resumes at row 5, plane 3, with no frame_start.
- reset asserted during DISPLAY -> next cycle PANEL_OE=1, STB=0, CLK=0, PANEL_ADDR=0. After release with enable=1, frame_start pulses.
- PANEL_W=64, ROW_PAIRS=32, BITS=8, OE_BASE=1 -> 64 CLK edges per plane. Plane-7 OE-low width 128. Row time 8*130+255=1295. Frame time 41440.

Source files
------------

// File: rtl/hub75_bcm_driver_if.sv
// Framebuffer read bus between the HUB75 scanner and a synchronous pixel RAM.
// The RAM returns fb_rdata exactly one cycle after it sees fb_addr.
interface hub75_bcm_driver_if #(
  parameter int AW = 9,
  parameter int DW = 24
);
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_rdata;

  modport master (output fb_addr, input fb_rdata);
  modport slave  (input fb_addr, output fb_rdata);
endinterface

// File: rtl/hub75_bcm_driver.sv
// HUB75 panel scanner with binary-coded modulation.
// Each row pair is sent BITS times, once per bit plane: the plane is shifted in,
// blanked, latched, then shown for OE_BASE<<plane cycles. Every output is registered.
module hub75_bcm_driver #(
  parameter int PANEL_W   = 32,
  parameter int ROW_PAIRS = 16,
  parameter int BITS      = 4,
  parameter int OE_BASE   = 8,
  localparam int RB       = $clog2(ROW_PAIRS),
  localparam int CB       = $clog2(PANEL_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  hub75_bcm_driver_if.master  fb,
  output logic                frame_start,
  output logic                PANEL_R0,
  output logic                PANEL_G0,
  output logic                PANEL_B0,
  output logic                PANEL_R1,
  output logic                PANEL_G1,
  output logic                PANEL_B1,
  output logic [RB-1:0]       PANEL_ADDR,
  output logic                PANEL_CLK,
  output logic                PANEL_STB,
  output logic                PANEL_OE
);

  localparam int SHIFT_LEN = 2 * PANEL_W;
  localparam int DISP_MAX  = OE_BASE << (BITS - 1);
  localparam int CNT_MAX   = (SHIFT_LEN > DISP_MAX) ? SHIFT_LEN : DISP_MAX;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int PB        = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [RB-1:0]   row, row_d, row_next;
  logic [PB-1:0]   plane, plane_d;
  logic [CW-1:0]   disp_len;
  logic [CW-1:0]   half;
  logic            shift_done, disp_done, last_plane;

  // Registered output state and its next values
  logic [5:0]      rgb, rgb_d;           // {R1,G1,B1,R0,G0,B0}
  logic [RB+CB-1:0] fb_addr_q, fb_addr_d;
  logic [RB-1:0]   paddr_d;
  logic            oe_d, stb_d, pclk_d, fs_d;

  // Selects one bit plane from a pixel pair, packed as {R1,G1,B1,R0,G0,B0}
  function automatic logic [5:0] plane_bits(input logic [6*BITS-1:0] d,
                                            input logic [PB-1:0]     p);
    logic [BITS-1:0] top_b, top_g, top_r, bot_b, bot_g, bot_r;
    top_b = d[BITS-1:0];
    top_g = d[2*BITS-1:BITS];
    top_r = d[3*BITS-1:2*BITS];
    bot_b = d[4*BITS-1:3*BITS];
    bot_g = d[5*BITS-1:4*BITS];
    bot_r = d[6*BITS-1:5*BITS];
    return {bot_r[p], bot_g[p], bot_b[p], top_r[p], top_g[p], top_b[p]};
  endfunction

  assign disp_len   = CW'(OE_BASE) << plane;
  assign shift_done = (cnt == CW'(SHIFT_LEN - 1));
  assign disp_done  = (cnt == disp_len - CW'(1));
  assign last_plane = (plane == PB'(BITS - 1));
  // Row that the following plane will scan; ROW_PAIRS is a power of two so it wraps
  assign row_next   = last_plane ? row + RB'(1) : row;

  // State, cycle counter, row and plane registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      row   <= '0;
      plane <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      row   <= row_d;
      plane <= plane_d;
    end
  end

  // Next-state logic; enable is only looked at from IDLE and at the end of a plane
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    row_d   = row;
    plane_d = plane;
    case (state)
      IDLE: begin
        if (enable) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (shift_done) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      BLANK: state_d = LATCH;
      LATCH: begin
        state_d = DISPLAY;
        cnt_d   = '0;
      end
      DISPLAY: begin
        if (disp_done) begin
          cnt_d   = '0;
          plane_d = last_plane ? '0 : plane + PB'(1);
          row_d   = row_next;
          state_d = enable ? SHIFT : IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign half = cnt_d >> 1;

  // Next values of the registered outputs, derived from the upcoming state.
  // The RAM needs fb_addr two cycles ahead of the colour pins, so during SHIFT the
  // address runs one pixel ahead, and from BLANK onwards it parks on pixel 0 of the
  // next plane's row so the first pixel is ready whenever SHIFT is entered.
  always_comb begin
    oe_d      = (state_d != DISPLAY);
    stb_d     = (state_d == LATCH);
    pclk_d    = (state_d == SHIFT) && cnt_d[0];
    fs_d      = (state_d == SHIFT) && (state != SHIFT) && (row_d == '0) && (plane_d == '0);
    rgb_d     = '0;
    paddr_d   = PANEL_ADDR;
    fb_addr_d = fb_addr_q;
    if (state_d == SHIFT) begin
      if (cnt_d[0]) begin
        rgb_d = rgb;
      end else begin
        rgb_d = plane_bits(fb.fb_rdata, plane_d);
        if (half < CW'(PANEL_W - 1)) begin
          fb_addr_d = {row_d, CB'(half + CW'(1))};
        end
      end
    end
    if (state_d == BLANK) begin
      paddr_d   = row;
      fb_addr_d = {row_next, {CB{1'b0}}};
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      PANEL_OE    <= 1'b1;
      PANEL_STB   <= 1'b0;
      PANEL_CLK   <= 1'b0;
      PANEL_ADDR  <= '0;
      rgb         <= '0;
      fb_addr_q   <= '0;
      frame_start <= 1'b0;
    end else begin
      PANEL_OE    <= oe_d;
      PANEL_STB   <= stb_d;
      PANEL_CLK   <= pclk_d;
      PANEL_ADDR  <= paddr_d;
      rgb         <= rgb_d;
      fb_addr_q   <= fb_addr_d;
      frame_start <= fs_d;
    end
  end

  assign fb.fb_addr = fb_addr_q;
  assign PANEL_R1   = rgb[5];
  assign PANEL_G1   = rgb[4];
  assign PANEL_B1   = rgb[3];
  assign PANEL_R0   = rgb[2];
  assign PANEL_G0   = rgb[1];
  assign PANEL_B0   = rgb[0];

endmodule
